vram_access_scheduler: RTL and testbench

- Single-port arbiter and sequencer for the compressed 8-bit VRAM (block RAM, 1-cycle read latency).
- Shares the VRAM between three requesters:
  - display-controller pixel reads;
  - touch-driven paint writes from the etch-a-sketch drawing logic;
  - an internal clear engine that sweeps every address with a fill colour.
- Sits between the VRAM instance and both the display path and the paint path. It is the only block driving VRAM address and write-enable.

---
 rtl/vram_access_scheduler_pkg.sv | 27 ++
 rtl/vram_access_scheduler_clear.sv | 82 ++++++++
 rtl/vram_access_scheduler.sv | 104 ++++++++++
 tb/tb_vram_access_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_access_scheduler_pkg.sv
// Shared VRAM geometry, colour constants and scheduler state encoding for the
// display / paint / clear access scheduler.
package vram_pkg;

  localparam int DEF_DISPLAY_WIDTH  = 240;
  localparam int DEF_DISPLAY_HEIGHT = 320;

  // One compressed word covers a 2x2 pixel block.
  function automatic int vram_len(input int width, input int height);
    return (width * height) / 4;
  endfunction

  localparam int VRAM_LEN_DEF = vram_len(DEF_DISPLAY_WIDTH, DEF_DISPLAY_HEIGHT);
  localparam int VRAM_AW_DEF  = $clog2(VRAM_LEN_DEF);

  typedef logic [VRAM_AW_DEF-1:0] vram_addr_t;

  localparam logic [7:0] COMP_BLACK = 8'h00;
  localparam logic [7:0] COMP_WHITE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/vram_access_scheduler_clear.sv
// Clear engine: sweeps every VRAM word with a latched fill colour, pausing on
// any cycle the display path owns the RAM.
module vram_clear_sequencer
  import vram_pkg::*;
#(
  parameter int VRAM_L = VRAM_LEN_DEF,
  parameter int AW     = $clog2(VRAM_L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ena,
  input  logic          i_start,
  input  logic [7:0]    i_color,
  input  logic          i_stall,
  output logic          o_wr_en,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data,
  output logic          o_idle,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);

  sched_state_e  r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_color;
  logic          r_busy;
  logic          r_done;

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_ena) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_color <= i_color;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // A stalled cycle writes nothing, so the address must hold.
          if (!i_stall) begin
            if (r_addr == LAST_ADDR) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_en = r_busy & i_ena & ~i_stall;
  assign o_addr  = r_addr;
  assign o_data  = r_color;
  assign o_idle  = (r_state == S_IDLE);
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/vram_access_scheduler.sv
// Single-port VRAM arbiter: display reads beat clear writes, which beat paint
// writes. The RAM address/write mux is combinational; read data passes through.
module vram_access_scheduler
  import vram_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
  parameter int VRAM_L         = (DISPLAY_WIDTH * DISPLAY_HEIGHT) / 4,
  parameter int AW             = $clog2(VRAM_L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          disp_rd_req,
  input  logic [AW-1:0] disp_rd_addr,
  output logic          disp_rd_valid,
  output logic [7:0]    disp_rd_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clear_req,
  input  logic [7:0]    clear_color,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          oob_error,
  output logic [AW-1:0] vram_addr,
  output logic          vram_wr_ena,
  output logic [7:0]    vram_wr_data,
  input  logic [7:0]    vram_rd_data
);

  localparam logic [AW-1:0] VRAM_LEN = AW'(VRAM_L);

  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic [7:0]    w_clr_data;
  logic          w_clr_idle;
  logic          w_paint_fire;
  logic          w_paint_in_range;
  logic          r_disp_rd_valid;
  logic          r_oob_error;

  vram_clear_sequencer #(
    .VRAM_L (VRAM_L),
    .AW     (AW)
  ) u_clear (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (ena),
    .i_start (clear_req),
    .i_color (clear_color),
    .i_stall (disp_rd_req),
    .o_wr_en (w_clr_we),
    .o_addr  (w_clr_addr),
    .o_data  (w_clr_data),
    .o_idle  (w_clr_idle),
    .o_busy  (clear_busy),
    .o_done  (clear_done)
  );

  // Combinational ready: the paint master must not wait on it before asserting valid.
  assign wr_ready         = ena & ~rst & ~disp_rd_req & w_clr_idle;
  assign w_paint_fire     = wr_valid & wr_ready;
  assign w_paint_in_range = (wr_addr < VRAM_LEN);

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    vram_addr    = '0;
    vram_wr_ena  = 1'b0;
    vram_wr_data = '0;
    if (!rst) begin
      if (disp_rd_req) begin
        vram_addr = disp_rd_addr;
      end else if (w_clr_we) begin
        vram_addr    = w_clr_addr;
        vram_wr_ena  = 1'b1;
        vram_wr_data = w_clr_data;
      end else if (w_paint_fire && w_paint_in_range) begin
        vram_addr    = wr_addr;
        vram_wr_ena  = 1'b1;
        vram_wr_data = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_rd_valid <= 1'b0;
      r_oob_error     <= 1'b0;
    end else begin
      r_disp_rd_valid <= disp_rd_req & ena;
      if (w_paint_fire && !w_paint_in_range) begin
        r_oob_error <= 1'b1;
      end
    end
  end

  assign disp_rd_valid = r_disp_rd_valid;
  assign disp_rd_data  = vram_rd_data;
  assign oob_error     = r_oob_error;

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a behavioural 1-cycle-latency
// block RAM attached to the VRAM port.
module tb_vram_access_scheduler;
  import vram_pkg::*;

  localparam int L  = VRAM_LEN_DEF;
  localparam int AW = VRAM_AW_DEF;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          disp_rd_req;
  vram_addr_t    disp_rd_addr;
  logic          disp_rd_valid;
  logic [7:0]    disp_rd_data;
  logic          wr_valid;
  logic          wr_ready;
  vram_addr_t    wr_addr;
  logic [7:0]    wr_data;
  logic          clear_req;
  logic [7:0]    clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic          oob_error;
  vram_addr_t    vram_addr;
  logic          vram_wr_ena;
  logic [7:0]    vram_wr_data;
  logic [7:0]    vram_rd_data;

  int checks   = 0;
  int failures = 0;

  vram_access_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .disp_rd_req   (disp_rd_req),
    .disp_rd_addr  (disp_rd_addr),
    .disp_rd_valid (disp_rd_valid),
    .disp_rd_data  (disp_rd_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .clear_req     (clear_req),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .oob_error     (oob_error),
    .vram_addr     (vram_addr),
    .vram_wr_ena   (vram_wr_ena),
    .vram_wr_data  (vram_wr_data),
    .vram_rd_data  (vram_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural block RAM, read-before-write, registered output.
  logic [7:0] mem [L];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < L; i++) mem[i] <= 8'h11;
      mem[100] <= 8'h3C;
    end else begin
      if (vram_wr_ena && (int'(vram_addr) < L)) mem[vram_addr] <= vram_wr_data;
      if (int'(vram_addr) < L) vram_rd_data <= mem[vram_addr];
      else                     vram_rd_data <= 8'h00;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the test finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ena;
    logic       rd_req;
    int         rd_addr;
    logic       wr_valid;
    int         wr_addr;
    logic [7:0] wr_data;
    logic       e_ready;
    logic       e_we;
    int         e_addr;
    logic [7:0] e_wdata;
    logic       e_valid;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vec [12];

  initial begin
    int errs;
    int rd_errs;
    int rdy_errs;
    int done_cnt;
    int cycles;
    int nreads;
    int exp_addr;
    int guard;
    logic found;

    vec[0]  = '{1'b1, 1'b0, 0,     1'b0, 0,     8'h00, 1'b1, 1'b0, 0,     8'h00, 1'b0, 8'h00};
    vec[1]  = '{1'b1, 1'b1, 100,   1'b0, 0,     8'h00, 1'b0, 1'b0, 100,   8'h00, 1'b1, 8'h3C};
    vec[2]  = '{1'b1, 1'b0, 0,     1'b1, 5,     8'hA5, 1'b1, 1'b1, 5,     8'hA5, 1'b0, 8'h00};
    vec[3]  = '{1'b1, 1'b1, 5,     1'b0, 0,     8'h00, 1'b0, 1'b0, 5,     8'h00, 1'b1, 8'hA5};
    vec[4]  = '{1'b1, 1'b1, 7,     1'b1, 7,     8'h66, 1'b0, 1'b0, 7,     8'h00, 1'b1, 8'h11};
    vec[5]  = '{1'b1, 1'b0, 0,     1'b1, 7,     8'h66, 1'b1, 1'b1, 7,     8'h66, 1'b0, 8'h00};
    vec[6]  = '{1'b1, 1'b1, 7,     1'b0, 0,     8'h00, 1'b0, 1'b0, 7,     8'h00, 1'b1, 8'h66};
    vec[7]  = '{1'b1, 1'b0, 0,     1'b1, L-1,   8'hF0, 1'b1, 1'b1, L-1,   8'hF0, 1'b0, 8'h00};
    vec[8]  = '{1'b1, 1'b1, L-1,   1'b0, 0,     8'h00, 1'b0, 1'b0, L-1,   8'h00, 1'b1, 8'hF0};
    vec[9]  = '{1'b0, 1'b0, 0,     1'b1, 9,     8'h77, 1'b0, 1'b0, 0,     8'h00, 1'b0, 8'h00};
    vec[10] = '{1'b0, 1'b1, 3,     1'b0, 0,     8'h00, 1'b0, 1'b0, 3,     8'h00, 1'b0, 8'h00};
    vec[11] = '{1'b1, 1'b0, 0,     1'b0, 0,     8'h00, 1'b1, 1'b0, 0,     8'h00, 1'b0, 8'h00};

    rst = 1'b1; ena = 1'b1; mem_init = 1'b1;
    disp_rd_req = 1'b0; disp_rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    tick();
    mem_init = 1'b0;
    tick();
    check("reset clear_busy",    32'(clear_busy),    0);
    check("reset clear_done",    32'(clear_done),    0);
    check("reset oob_error",     32'(oob_error),     0);
    check("reset disp_rd_valid", 32'(disp_rd_valid), 0);
    check("reset vram_wr_ena",   32'(vram_wr_ena),   0);
    check("reset vram_addr",     32'(vram_addr),     0);
    check("reset vram_wr_data",  32'(vram_wr_data),  0);
    rst = 1'b0;
    tick();

    // Table: reads, paint writes, read/write conflict, enable low.
    for (int i = 0; i < 12; i++) begin
      ena          = vec[i].ena;
      disp_rd_req  = vec[i].rd_req;
      disp_rd_addr = AW'(vec[i].rd_addr);
      wr_valid     = vec[i].wr_valid;
      wr_addr      = AW'(vec[i].wr_addr);
      wr_data      = vec[i].wr_data;
      #1;
      check($sformatf("vec%0d wr_ready", i),     32'(wr_ready),     32'(vec[i].e_ready));
      check($sformatf("vec%0d vram_wr_ena", i),  32'(vram_wr_ena),  32'(vec[i].e_we));
      check($sformatf("vec%0d vram_addr", i),    32'(vram_addr),    32'(vec[i].e_addr));
      if (vec[i].e_we)
        check($sformatf("vec%0d vram_wr_data", i), 32'(vram_wr_data), 32'(vec[i].e_wdata));
      tick();
      check($sformatf("vec%0d disp_rd_valid", i), 32'(disp_rd_valid), 32'(vec[i].e_valid));
      if (vec[i].e_valid)
        check($sformatf("vec%0d disp_rd_data", i), 32'(disp_rd_data), 32'(vec[i].e_rdata));
    end
    ena = 1'b1; disp_rd_req = 1'b0; wr_valid = 1'b0;

    // Out-of-range paint write is consumed without touching the RAM.
    wr_valid = 1'b1; wr_addr = AW'(L); wr_data = 8'hEE;
    #1;
    check("oob wr_ready",    32'(wr_ready),    1);
    check("oob vram_wr_ena", 32'(vram_wr_ena), 0);
    tick();
    wr_valid = 1'b0;
    check("oob flag set", 32'(oob_error), 1);
    repeat (3) tick();
    check("oob flag sticky", 32'(oob_error), 1);

    // Clear to black, issued together with a paint write to address 10.
    clear_req = 1'b1; clear_color = COMP_BLACK;
    wr_valid = 1'b1; wr_addr = AW'(10); wr_data = 8'h5A;
    #1;
    check("clr+paint wr_ready",     32'(wr_ready),     1);
    check("clr+paint vram_wr_ena",  32'(vram_wr_ena),  1);
    check("clr+paint vram_addr",    32'(vram_addr),    10);
    check("clr+paint vram_wr_data", 32'(vram_wr_data), 32'h5A);
    tick();
    clear_req = 1'b0; wr_valid = 1'b0; clear_color = 8'h99;
    check("clear1 busy after start", 32'(clear_busy), 1);
    errs = 0; rdy_errs = 0; done_cnt = 0; cycles = 0; exp_addr = 0;
    while (clear_busy && cycles < 25000) begin
      wr_valid = 1'b1; wr_addr = AW'(20); wr_data = 8'h42;
      #1;
      if (!vram_wr_ena || int'(vram_addr) != exp_addr || vram_wr_data != COMP_BLACK) errs++;
      exp_addr++;
      if (wr_ready) rdy_errs++;
      tick();
      if (clear_done) done_cnt++;
      cycles++;
    end
    wr_valid = 1'b0;
    check("clear1 busy cycles",     32'(cycles),   32'(L));
    check("clear1 write sequence",  32'(errs),     0);
    check("clear1 wr_ready low",    32'(rdy_errs), 0);
    check("clear1 done at end",     32'(clear_done), 1);
    tick();
    if (clear_done) done_cnt++;
    check("clear1 done pulses",     32'(done_cnt), 1);
    check("clear1 wr_ready after",  32'(wr_ready), 1);

    errs = 0;
    for (int a = 0; a < L; a++) begin
      disp_rd_req = 1'b1; disp_rd_addr = AW'(a);
      tick();
      if (!disp_rd_valid || disp_rd_data != COMP_BLACK) errs++;
    end
    disp_rd_req = 1'b0;
    check("clear1 readback all black", 32'(errs), 0);
    tick();

    // Clear to white with a display read every 10th cycle and a stray clear_req.
    clear_req = 1'b1; clear_color = COMP_WHITE;
    tick();
    clear_req = 1'b0;
    errs = 0; rd_errs = 0; rdy_errs = 0; done_cnt = 0; cycles = 0; nreads = 0; exp_addr = 0;
    while (clear_busy && cycles < 25000) begin
      disp_rd_req  = (cycles % 10 == 9);
      disp_rd_addr = '0;
      clear_req    = (cycles == 50);
      clear_color  = 8'h00;
      #1;
      if (disp_rd_req) begin
        nreads++;
        if (vram_wr_ena || vram_addr != '0) errs++;
      end else begin
        if (!vram_wr_ena || int'(vram_addr) != exp_addr || vram_wr_data != COMP_WHITE) errs++;
        exp_addr++;
      end
      if (wr_ready) rdy_errs++;
      tick();
      if (disp_rd_req && (!disp_rd_valid || disp_rd_data != COMP_WHITE)) rd_errs++;
      if (clear_done) done_cnt++;
      disp_rd_req = 1'b0; clear_req = 1'b0;
      cycles++;
    end
    check("clear2 busy cycles",     32'(cycles),   32'(L + nreads));
    check("clear2 addresses swept", 32'(exp_addr), 32'(L));
    check("clear2 write/stall seq", 32'(errs),     0);
    check("clear2 reads valid",     32'(rd_errs),  0);
    check("clear2 wr_ready low",    32'(rdy_errs), 0);
    tick();
    if (clear_done) done_cnt++;
    check("clear2 done pulses",     32'(done_cnt), 1);

    // Reset in the middle of a sweep aborts it without a done pulse.
    clear_req = 1'b1; clear_color = COMP_BLACK;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 1000) begin
      if (vram_wr_ena && int'(vram_addr) == 500) found = 1'b1;
      else begin
        tick();
        guard++;
      end
    end
    check("abort reached addr 500", 32'(found), 1);
    rst = 1'b1;
    tick();
    check("abort busy in reset", 32'(clear_busy), 0);
    check("abort done in reset", 32'(clear_done), 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (clear_done) done_cnt++;
      tick();
    end
    check("abort no done pulse", 32'(done_cnt),   0);
    check("abort busy low",      32'(clear_busy), 0);
    check("abort wr_ready",      32'(wr_ready),   1);
    check("oob cleared by rst",  32'(oob_error),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
